mod_adder_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `ModAdder` instance among `NUM_REQ` requesters in the Poseidon round datapath. Each requester presents an operand pair under a valid/ready handshake. The winning pair is reduced modulo `MODULUS`, and the sum is captured in a single output register tagged with the requester index. Throughput is one modular addition per cycle when downstream does not stall.

---
 rtl/poseidon_pkg.sv | 14 +
 rtl/ModAdder.sv | 32 +++
 rtl/mod_adder_arbiter.sv | 105 ++++++++++
 tb/tb_mod_adder_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poseidon_pkg.sv
// Shared constants for the Poseidon round datapath.
// BLS12-381 scalar field modulus and its 2^W complement.
package poseidon_pkg;

    localparam int DEFAULT_DATA_WIDTH = 255;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] BLS_MODULUS =
        255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    // 2^W - MODULUS, the value added to wrap a sum back into range.
    localparam logic [DEFAULT_DATA_WIDTH-1:0] BLS_MOD_COMPENSATION =
        {DEFAULT_DATA_WIDTH{1'b0}} - BLS_MODULUS;

endpackage

// File: rtl/ModAdder.sv
// Combinational modular adder: (op1 + op2) mod MODULUS.
// Inputs must already be below MODULUS.
module ModAdder
    import poseidon_pkg::*;
#(
    parameter int                    DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] MODULUS          = BLS_MODULUS,
    parameter logic [DATA_WIDTH-1:0] MOD_COMPENSATION = BLS_MOD_COMPENSATION
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] res
);

    logic [DATA_WIDTH:0] sum1;
    logic [DATA_WIDTH:0] sum2;
    logic                carry1;
    logic                carry2;

    // sum >= MODULUS exactly when the raw add overflows (carry1)
    // or adding the compensation overflows (carry2); either way
    // the compensated sum is the reduced result.
    always_comb begin
        sum1   = {1'b0, op1} + {1'b0, op2};
        carry1 = sum1[DATA_WIDTH];
        sum2   = {1'b0, sum1[DATA_WIDTH-1:0]} + {1'b0, MOD_COMPENSATION};
        carry2 = sum2[DATA_WIDTH];
        res    = (carry1 | carry2) ? sum2[DATA_WIDTH-1:0]
                                   : sum1[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/mod_adder_arbiter.sv
// Round-robin arbiter sharing one ModAdder among NUM_REQ requesters.
// Result is held in a single tagged output register.
module mod_adder_arbiter
    import poseidon_pkg::*;
#(
    parameter int                    NUM_REQ          = 4,
    parameter int                    ID_WIDTH         = 2,
    parameter int                    DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] MODULUS          = BLS_MODULUS,
    parameter logic [DATA_WIDTH-1:0] MOD_COMPENSATION =
        {DATA_WIDTH{1'b0}} - MODULUS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic                  can_accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] op1_sel;
    logic [DATA_WIDTH-1:0] op2_sel;
    logic [DATA_WIDTH-1:0] add_res;

    // Requester index at offset ofs from base, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] idx_at(
        input logic [PTR_W-1:0] base,
        input int               ofs
    );
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    assign can_accept = !rsp_valid_o || rsp_ready_i;

    // Priority search starting at rr_ptr; first valid index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req_valid_i[idx_at(rr_ptr, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_at(rr_ptr, i);
            end
        end
    end

    // Only the winner sees ready, and only when the register can take it.
    always_comb begin
        req_ready_o = '0;
        if (!reset && gnt_any && can_accept) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(req_valid_i & req_ready_o);

    // Route the winning operand pair to the shared adder.
    always_comb begin
        op1_sel = req_op1_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        op2_sel = req_op2_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    ModAdder #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MODULUS         (MODULUS),
        .MOD_COMPENSATION(MOD_COMPENSATION)
    ) u_add (
        .op1(op1_sel),
        .op2(op2_sel),
        .res(add_res)
    );

    // Output register: load on transfer, clear valid on drain;
    // priority rotates only past a served requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= add_res;
            rsp_id_o    <= ID_WIDTH'(gnt_idx);
            rr_ptr      <= idx_at(gnt_idx, 1);
        end else if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_adder_arbiter.sv
// Randomized bench for mod_adder_arbiter against a plain-arithmetic model.
// Also runs the 255-bit default build on carry-path corner cases.
module tb_mod_adder_arbiter;
    import poseidon_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int MW = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [N-1:0]   vld;
    logic [N-1:0]   rdy_o;
    logic [N*W-1:0] op1;
    logic [N*W-1:0] op2;
    logic           rsp_rdy;
    logic           rsp_vld;
    logic [W-1:0]   rsp_data;
    logic [IW-1:0]  rsp_id;

    logic [N-1:0]    wvld;
    logic [N-1:0]    wrdy_o;
    logic [N*MW-1:0] wop1;
    logic [N*MW-1:0] wop2;
    logic            wrsp_rdy;
    logic            wrsp_vld;
    logic [MW-1:0]   wdata;
    logic [IW-1:0]   wid;

    mod_adder_arbiter #(
        .NUM_REQ         (N),
        .ID_WIDTH        (IW),
        .DATA_WIDTH      (W),
        .MODULUS         (8'd251),
        .MOD_COMPENSATION(8'd5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(vld),
        .req_ready_o(rdy_o),
        .req_op1_i  (op1),
        .req_op2_i  (op2),
        .rsp_valid_o(rsp_vld),
        .rsp_ready_i(rsp_rdy),
        .rsp_data_o (rsp_data),
        .rsp_id_o   (rsp_id)
    );

    mod_adder_arbiter dut_wide (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(wvld),
        .req_ready_o(wrdy_o),
        .req_op1_i  (wop1),
        .req_op2_i  (wop2),
        .rsp_valid_o(wrsp_vld),
        .rsp_ready_i(wrsp_rdy),
        .rsp_data_o (wdata),
        .rsp_id_o   (wid)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents and next-priority requester.
    int m_valid = 0;
    int m_data  = 0;
    int m_id    = 0;
    int m_ptr   = 0;

    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            if (vld[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_ops(input int k, input int a, input int b);
        op1[k*W +: W] = W'(a);
        op2[k*W +: W] = W'(b);
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            set_ops(k, $urandom_range(0, 250), $urandom_range(0, 250));
        end
    endtask

    // One clock: inputs already driven just after the previous edge.
    task automatic tick();
        int k;
        bit can;
        logic [N-1:0] er;
        #4;
        k   = pick();
        can = (m_valid == 0) || rsp_rdy;
        er  = '0;
        if (!reset && k >= 0 && can) er[k] = 1'b1;
        chk("req_ready", 256'(rdy_o), 256'(er));
        @(posedge clk);
        if (reset) begin
            m_valid = 0;
            m_data  = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (er != '0) begin
            m_data  = (int'(op1[k*W +: W]) + int'(op2[k*W +: W])) % 251;
            m_id    = k;
            m_valid = 1;
            m_ptr   = (k + 1) % N;
        end else if (m_valid != 0 && rsp_rdy) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 256'(rsp_vld), 256'(m_valid));
        if (m_valid != 0) begin
            chk("rsp_data", 256'(rsp_data), 256'(m_data));
            chk("rsp_id", 256'(rsp_id), 256'(m_id));
        end
    endtask

    logic [W-1:0]  hold_d;
    logic [IW-1:0] hold_i;
    logic [MW-1:0] mm1;

    initial begin
        reset    = 1'b1;
        vld      = '1;
        rsp_rdy  = 1'b1;
        op1      = '0;
        op2      = '0;
        wvld     = '0;
        wop1     = '0;
        wop2     = '0;
        wrsp_rdy = 1'b1;
        rand_ops();
        @(posedge clk);
        #1;

        // reset with all requesters valid
        repeat (2) tick();
        chk("rst_data", 256'(rsp_data), 256'd0);
        chk("rst_id", 256'(rsp_id), 256'd0);

        // round robin, no bubbles, first grant to 0
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            tick();
            chk("rr_id", 256'(rsp_id), 256'(i % N));
            chk("rr_vld", 256'(rsp_vld), 256'd1);
        end

        // sparse priority after 3 served, idle cycles keep pointer
        vld = 4'b1010;
        tick();
        chk("sparse1", 256'(rsp_id), 256'd1);
        vld = 4'b0000;
        repeat (3) tick();
        vld = 4'b1010;
        tick();
        chk("sparse3", 256'(rsp_id), 256'd3);

        // wrap cases from requester 2
        vld = 4'b0100;
        set_ops(2, 200, 100);
        tick();
        chk("wrap49", 256'(rsp_data), 256'd49);
        chk("wrap_id", 256'(rsp_id), 256'd2);
        set_ops(2, 250, 0);
        tick();
        chk("wrap250", 256'(rsp_data), 256'd250);
        set_ops(2, 125, 126);
        tick();
        chk("wrap0", 256'(rsp_data), 256'd0);

        // backpressure for 3 cycles, then drain + accept together
        vld = '1;
        rand_ops();
        tick();
        hold_d  = rsp_data;
        hold_i  = rsp_id;
        rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
            chk("bp_ready", 256'(rdy_o), 256'd0);
            chk("bp_data", 256'(rsp_data), 256'(hold_d));
            chk("bp_id", 256'(rsp_id), 256'(hold_i));
        end
        rsp_rdy = 1'b1;
        tick();
        chk("bp_next_id", 256'(rsp_id), 256'((int'(hold_i) + 1) % N));

        // reset while stalled discards the held result
        rsp_rdy = 1'b0;
        reset   = 1'b1;
        tick();
        chk("mid_rst", 256'(rsp_vld), 256'd0);
        reset   = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            vld     = N'($urandom);
            rsp_rdy = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 63) == 0);
            rand_ops();
            tick();
        end
        reset   = 1'b0;
        rsp_rdy = 1'b1;
        vld     = '0;
        tick();

        // 255-bit default build
        mm1  = BLS_MODULUS - 1'b1;
        wvld = 4'b0001;
        wop1[0 +: MW] = mm1;
        wop2[0 +: MW] = MW'(1);
        @(posedge clk);
        #1;
        chk("wide_vld", 256'(wrsp_vld), 256'd1);
        chk("wide_zero", 256'(wdata), 256'd0);
        wop2[0 +: MW] = mm1;
        @(posedge clk);
        #1;
        chk("wide_m2", 256'(wdata), 256'(BLS_MODULUS - 2'd2));
        wvld = '0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
